mem_stage: RTL

Memory-access pipeline stage of the Ultiparc core, directly downstream of execute. It consumes execute's registered result, destination, LSU command and store data. It runs at most one load or store per instruction on the data bus through a small FSM and raises `o_mem_stall` while the access is outstanding. It delivers the write-back register number and value to the write-back stage.

---
 rtl/mem_stage_pkg.sv | 35 +++
 rtl/mem_stage_if.sv | 16 +
 rtl/mem_stage_lsu_lane.sv | 56 +++++
 rtl/mem_stage.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the Ultiparc memory-access stage.
// The package also holds the alignment rule that the stage uses.
package mem_stage_pkg;

  localparam int CPU_ADDR_WIDTH  = 32;
  localparam int CPU_DATA_WIDTH  = 32;
  localparam int CPU_REG_WIDTH   = 32;
  localparam int CPU_REGNO_WIDTH = 5;
  localparam int CPU_LSUOP_WIDTH = 2;

  typedef enum logic [CPU_LSUOP_WIDTH-1:0] {
    CPU_LSU_IDLE = 2'd0,
    CPU_LSU_BYTE = 2'd1,
    CPU_LSU_HALF = 2'd2,
    CPU_LSU_WORD = 2'd3
  } lsu_op_e;

  typedef enum logic [1:0] {
    MEM_ST_IDLE    = 2'd0,
    MEM_ST_CMD     = 2'd1,
    MEM_ST_WAIT_RD = 2'd2
  } mem_state_e;

  // A halfword must sit on an even address and a word on a multiple of four.
  function automatic logic lsu_misaligned(input lsu_op_e op, input logic [1:0] lane);
    logic mis;
    case (op)
      CPU_LSU_HALF: mis = lane[0];
      CPU_LSU_WORD: mis = (lane != 2'b00);
      default:      mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-bus connection between the memory stage (master) and the interconnect (slave).
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic [CPU_ADDR_WIDTH-1:0] addr;
  logic                      cmd;
  logic                      rnw;
  logic [CPU_DATA_WIDTH-1:0] wdata;
  logic [3:0]                ben;
  logic                      rdy;
  logic [CPU_DATA_WIDTH-1:0] rdata;
  logic                      dvalid;

  modport master (output addr, cmd, rnw, wdata, ben, input rdy, rdata, dvalid);
  modport slave  (input addr, cmd, rnw, wdata, ben, output rdy, rdata, dvalid);
endinterface

// File: rtl/mem_stage_lsu_lane.sv
// Little-endian byte-lane steering: store replication and byte enables,
// plus load lane extraction with sign or zero extension.
module lsu_lane
  import mem_stage_pkg::*;
(
  input  lsu_op_e                   st_op,
  input  logic [1:0]                st_lane,
  input  logic [CPU_DATA_WIDTH-1:0] st_data,
  output logic [CPU_DATA_WIDTH-1:0] st_wdata,
  output logic [3:0]                st_ben,
  input  lsu_op_e                   ld_op,
  input  logic [1:0]                ld_lane,
  input  logic                      ld_ext,
  input  logic [CPU_DATA_WIDTH-1:0] ld_data,
  output logic [CPU_DATA_WIDTH-1:0] ld_val
);

  logic [CPU_DATA_WIDTH-1:0] shifted_s;

  // Store side: replicate the operand across every lane of its size.
  always_comb begin
    st_wdata = 32'h0000_0000;
    st_ben   = 4'b0000;
    case (st_op)
      CPU_LSU_BYTE: begin
        st_wdata = {4{st_data[7:0]}};
        st_ben   = 4'b0001 << st_lane;
      end
      CPU_LSU_HALF: begin
        st_wdata = {2{st_data[15:0]}};
        st_ben   = st_lane[1] ? 4'b1100 : 4'b0011;
      end
      CPU_LSU_WORD: begin
        st_wdata = st_data;
        st_ben   = 4'b1111;
      end
      default: begin
        st_wdata = 32'h0000_0000;
        st_ben   = 4'b0000;
      end
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted_s = ld_data >> {ld_lane, 3'b000};
    ld_val    = 32'h0000_0000;
    case (ld_op)
      CPU_LSU_BYTE: ld_val = {{24{ld_ext & shifted_s[7]}}, shifted_s[7:0]};
      CPU_LSU_HALF: ld_val = {{16{ld_ext & shifted_s[15]}}, shifted_s[15:0]};
      CPU_LSU_WORD: ld_val = shifted_s;
      default:      ld_val = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues at most one load or store per instruction on the
// data bus and delivers the write-back register number and value.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_exec_stall,
  input  logic                       i_fetch_stall,
  input  logic [CPU_REGNO_WIDTH-1:0] i_rd_no,
  input  logic [CPU_REG_WIDTH-1:0]   i_alu_result,
  input  logic [CPU_LSUOP_WIDTH-1:0] i_lsu_op,
  input  logic                       i_lsu_lns,
  input  logic                       i_lsu_ext,
  input  logic [CPU_DATA_WIDTH-1:0]  i_mem_data,
  output logic                       o_mem_stall,
  output logic                       o_addr_err,
  output logic [CPU_REGNO_WIDTH-1:0] o_rd_no,
  output logic [CPU_REG_WIDTH-1:0]   o_rd_val,
  mem_stage_if.master                bus
);

  mem_state_e                 state_r,   state_nxt_s;
  logic [CPU_REGNO_WIDTH-1:0] rd_no_r,   rd_no_nxt_s;
  logic [CPU_REG_WIDTH-1:0]   rd_val_r,  rd_val_nxt_s;
  logic                       err_r,     err_nxt_s;
  logic                       cmd_r,     cmd_nxt_s;
  logic                       rnw_r,     rnw_nxt_s;
  logic [CPU_ADDR_WIDTH-1:0]  baddr_r,   baddr_nxt_s;
  logic [CPU_DATA_WIDTH-1:0]  wdata_r,   wdata_nxt_s;
  logic [3:0]                 ben_r,     ben_nxt_s;
  logic [1:0]                 lane_r,    lane_nxt_s;
  lsu_op_e                    op_r,      op_nxt_s;
  logic                       ext_r,     ext_nxt_s;
  logic [CPU_REGNO_WIDTH-1:0] rd_lat_r,  rd_lat_nxt_s;

  lsu_op_e                    op_in_s;
  logic                       capture_s;
  logic [CPU_DATA_WIDTH-1:0]  st_wdata_s;
  logic [3:0]                 st_ben_s;
  logic [CPU_DATA_WIDTH-1:0]  ld_val_s;

  assign op_in_s   = lsu_op_e'(i_lsu_op);
  assign capture_s = ~i_exec_stall & ~i_fetch_stall;

  lsu_lane u_lane (
    .st_op    (op_in_s),
    .st_lane  (i_alu_result[1:0]),
    .st_data  (i_mem_data),
    .st_wdata (st_wdata_s),
    .st_ben   (st_ben_s),
    .ld_op    (op_r),
    .ld_lane  (lane_r),
    .ld_ext   (ext_r),
    .ld_data  (bus.rdata),
    .ld_val   (ld_val_s)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt_s  = state_r;
    rd_no_nxt_s  = rd_no_r;
    rd_val_nxt_s = rd_val_r;
    err_nxt_s    = 1'b0;
    cmd_nxt_s    = cmd_r;
    rnw_nxt_s    = rnw_r;
    baddr_nxt_s  = baddr_r;
    wdata_nxt_s  = wdata_r;
    ben_nxt_s    = ben_r;
    lane_nxt_s   = lane_r;
    op_nxt_s     = op_r;
    ext_nxt_s    = ext_r;
    rd_lat_nxt_s = rd_lat_r;
    case (state_r)
      MEM_ST_IDLE: begin
        if (!capture_s) begin
          rd_no_nxt_s = {CPU_REGNO_WIDTH{1'b0}};
        end else if (op_in_s == CPU_LSU_IDLE) begin
          rd_no_nxt_s  = i_rd_no;
          rd_val_nxt_s = i_alu_result;
        end else begin
          rd_no_nxt_s  = {CPU_REGNO_WIDTH{1'b0}};
          lane_nxt_s   = i_alu_result[1:0];
          op_nxt_s     = op_in_s;
          ext_nxt_s    = i_lsu_ext;
          rd_lat_nxt_s = i_rd_no;
          if (lsu_misaligned(op_in_s, i_alu_result[1:0])) begin
            err_nxt_s = 1'b1;
          end else begin
            state_nxt_s = MEM_ST_CMD;
            cmd_nxt_s   = 1'b1;
            rnw_nxt_s   = i_lsu_lns;
            baddr_nxt_s = {i_alu_result[CPU_ADDR_WIDTH-1:2], 2'b00};
            wdata_nxt_s = st_wdata_s;
            ben_nxt_s   = st_ben_s;
          end
        end
      end
      MEM_ST_CMD: begin
        // Bus outputs are parked at zero once the command has been taken.
        if (bus.rdy) begin
          state_nxt_s = rnw_r ? MEM_ST_WAIT_RD : MEM_ST_IDLE;
          cmd_nxt_s   = 1'b0;
          rnw_nxt_s   = 1'b0;
          baddr_nxt_s = 32'h0000_0000;
          wdata_nxt_s = 32'h0000_0000;
          ben_nxt_s   = 4'b0000;
        end else begin
          state_nxt_s = MEM_ST_CMD;
        end
      end
      MEM_ST_WAIT_RD: begin
        if (bus.dvalid) begin
          state_nxt_s  = MEM_ST_IDLE;
          rd_no_nxt_s  = rd_lat_r;
          rd_val_nxt_s = ld_val_s;
        end else begin
          state_nxt_s = MEM_ST_WAIT_RD;
        end
      end
      default: state_nxt_s = MEM_ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= MEM_ST_IDLE;
      rd_no_r  <= {CPU_REGNO_WIDTH{1'b0}};
      rd_val_r <= 32'h0000_0000;
      err_r    <= 1'b0;
      cmd_r    <= 1'b0;
      rnw_r    <= 1'b0;
      baddr_r  <= 32'h0000_0000;
      wdata_r  <= 32'h0000_0000;
      ben_r    <= 4'b0000;
      lane_r   <= 2'b00;
      op_r     <= CPU_LSU_IDLE;
      ext_r    <= 1'b0;
      rd_lat_r <= {CPU_REGNO_WIDTH{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      rd_no_r  <= rd_no_nxt_s;
      rd_val_r <= rd_val_nxt_s;
      err_r    <= err_nxt_s;
      cmd_r    <= cmd_nxt_s;
      rnw_r    <= rnw_nxt_s;
      baddr_r  <= baddr_nxt_s;
      wdata_r  <= wdata_nxt_s;
      ben_r    <= ben_nxt_s;
      lane_r   <= lane_nxt_s;
      op_r     <= op_nxt_s;
      ext_r    <= ext_nxt_s;
      rd_lat_r <= rd_lat_nxt_s;
    end
  end

  assign o_mem_stall = (state_r != MEM_ST_IDLE);
  assign o_addr_err  = err_r;
  assign o_rd_no     = rd_no_r;
  assign o_rd_val    = rd_val_r;
  assign bus.addr    = baddr_r;
  assign bus.cmd     = cmd_r;
  assign bus.rnw     = rnw_r;
  assign bus.wdata   = wdata_r;
  assign bus.ben     = ben_r;

endmodule
